// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
// Decoded-instruction bus from the fetch unit to the control / register-file
// stage. Valid/ready handshake plus the address and decoded fields of the
// presented instruction.
//
// Signals
//   out_valid  fetch -> consumer  decoded instruction valid
//   out_ready  consumer -> fetch  transfer happens when out_valid && out_ready
//   pc_out     fetch -> consumer  address of the presented instruction
//   opcode     fetch -> consumer  top OP_W bits of the word
//   jump       fetch -> consumer  low 3*REG_W bits (jump target)
//   jiz        fetch -> consumer  low 2*REG_W bits (jump-if-zero target)
//   addA       fetch -> consumer  first register field
//   addB       fetch -> consumer  second register field
//   write_add  fetch -> consumer  destination register field
//   iformat    fetch -> consumer  same bits as write_add, format selector
//
// Modports: master = fetch unit, slave = consumer.
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int OP_W   = 4,
    parameter int REG_W  = 4,
    parameter int ADDR_W = 4
);
    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_W-1:0]    pc_out;
    logic [OP_W-1:0]      opcode;
    logic [3*REG_W-1:0]   jump;
    logic [2*REG_W-1:0]   jiz;
    logic [REG_W-1:0]     addA;
    logic [REG_W-1:0]     addB;
    logic [REG_W-1:0]     write_add;
    logic [REG_W-1:0]     iformat;

    modport master (
        output out_valid, pc_out, opcode, jump, jiz, addA, addB, write_add, iformat,
        input  out_ready
    );

    modport slave (
        input  out_valid, pc_out, opcode, jump, jiz, addA, addB, write_add, iformat,
        output out_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch and field decode for the 16-bit RISC core. A program
// counter walks a DEPTH-word instruction memory (combinational read); each
// fetched word is registered and presented, split into its fields, on a
// valid/ready bus. Supports jump redirect, consumer backpressure and HALT.
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous reset, active-low
//   en              fetch enable
//   redirect_valid  load PC with redirect_pc and flush the presented word
//   redirect_pc     jump target (taken modulo DEPTH)
//   halted          high while the unit sits in the HALTED state
//   ifu             decoded-instruction bus (instr_fetch_unit_if.master)
//   wr_en/wr_addr/wr_data  program-load write port, only with IMEM_WRITE_EN
//
// Build option
//   IMEM_WRITE_EN   defined: memory gets a write port (read-before-write on a
//                   same-cycle fetch, out-of-range addresses ignored).
//                   undefined: read-only memory, initialised to all zeros.
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              OP_W      = 4,
    parameter int              REG_W     = 4,
    parameter int              DEPTH     = 16,
    parameter int              ADDR_W    = 4,
    parameter logic [OP_W-1:0] HALT_OP   = 4'hF,
    parameter string           INIT_FILE = "",
    localparam int             INSTR_W   = OP_W + 3*REG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
`ifdef IMEM_WRITE_EN
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [INSTR_W-1:0]  wr_data,
`endif
    output logic                halted,
    instr_fetch_unit_if.master  ifu
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    logic [INSTR_W-1:0] imem [DEPTH];

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  redir_pc;
    logic [INSTR_W-1:0] rd_word;
    logic               fetch;
    logic               vld_d;

    logic [INSTR_W-1:0] instr_p1;
    logic [ADDR_W-1:0]  pc_p1;
    logic               vld_p1;

`ifdef IMEM_WRITE_EN
    // The fetch register samples rd_word at the same edge as this write, so a
    // same-cycle fetch of wr_addr naturally sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < 32'(DEPTH)))
            imem[wr_addr] <= wr_data;
    end
`else
    // Read-only program image.
    initial begin
        for (int i = 0; i < DEPTH; i++)
            imem[i] = '0;
    end
`endif

    assign rd_word  = imem[pc_q];
    // Explicit compare keeps the wrap correct for non-power-of-2 DEPTH.
    assign pc_inc   = (pc_q == ADDR_W'(DEPTH - 1)) ? '0 : pc_q + ADDR_W'(1);
    assign redir_pc = ADDR_W'(32'(redirect_pc) % 32'(DEPTH));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vld_d   = vld_p1;
        fetch   = 1'b0;
        if (redirect_valid) begin
            // Redirect beats fetch and stall and drops any unaccepted word.
            state_d = RUN;
            pc_d    = redir_pc;
            vld_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en)
                        state_d = RUN;
                end
                RUN: begin
                    if (en && (!vld_p1 || ifu.out_ready)) begin
                        fetch = 1'b1;
                        pc_d  = pc_inc;
                        vld_d = 1'b1;
                        if (rd_word[INSTR_W-1 -: OP_W] == HALT_OP)
                            state_d = HALTED;
                    end else if (vld_p1 && ifu.out_ready) begin
                        vld_d = 1'b0;
                    end
                end
                HALTED: begin
                    // The HALT word itself still has to be handed over.
                    if (vld_p1 && ifu.out_ready)
                        vld_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---- stage p1: registered fetch result ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            vld_p1   <= 1'b0;
            pc_p1    <= '0;
            instr_p1 <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vld_p1  <= vld_d;
            if (fetch) begin
                instr_p1 <= rd_word;
                pc_p1    <= pc_q;
            end
        end
    end

    assign halted        = (state_q == HALTED);
    assign ifu.out_valid = vld_p1;
    assign ifu.pc_out    = pc_p1;
    assign ifu.opcode    = instr_p1[INSTR_W-1 -: OP_W];
    assign ifu.jump      = instr_p1[3*REG_W-1:0];
    assign ifu.jiz       = instr_p1[2*REG_W-1:0];
    assign ifu.addA      = instr_p1[3*REG_W-1 -: REG_W];
    assign ifu.addB      = instr_p1[2*REG_W-1 -: REG_W];
    assign ifu.write_add = instr_p1[REG_W-1:0];
    assign ifu.iformat   = instr_p1[REG_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Scoreboard bench: the stimulus thread pushes the words the consumer is
// expected to accept; one monitor per DUT pops and compares on every
// handshake. Directed checks cover latency, stall, flush, HALT and reset.
// A DEPTH=12 instance exercises non-power-of-2 wrap and redirect modulo.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    typedef struct {
        logic [3:0]  pc;
        logic [15:0] word;
    } exp_t;

    logic clk;
    logic rst_n;
    logic en, rv;
    logic [3:0] rpc;
    logic halted;
    logic en2, rv2;
    logic [3:0] rpc2;
    logic halted2;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    exp_t exp12_q[$];

    logic [15:0] prog [16];

    instr_fetch_unit_if #(.OP_W(4), .REG_W(4), .ADDR_W(4)) bus();
    instr_fetch_unit_if #(.OP_W(4), .REG_W(4), .ADDR_W(4)) bus12();

`ifdef IMEM_WRITE_EN
    logic       wr_en, wr_en2;
    logic [3:0] wr_addr, wr_addr2;
    logic [15:0] wr_data, wr_data2;
`endif

    instr_fetch_unit #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .redirect_valid(rv), .redirect_pc(rpc),
`ifdef IMEM_WRITE_EN
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`endif
        .halted(halted), .ifu(bus)
    );

    instr_fetch_unit #(.DEPTH(12), .ADDR_W(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .en(en2),
        .redirect_valid(rv2), .redirect_pc(rpc2),
`ifdef IMEM_WRITE_EN
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
`endif
        .halted(halted2), .ifu(bus12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [43:0] fields(input logic [3:0] pc, input logic [15:0] w);
        return {pc, w[15:12], w[11:8], w[7:4], w[3:0], w[3:0], w[11:0], w[7:0]};
    endfunction

    function automatic void push(input logic [3:0] pc, input logic [15:0] w);
        exp_q.push_back('{pc: pc, word: w});
    endfunction

    function automatic void push12(input logic [3:0] pc, input logic [15:0] w);
        exp12_q.push_back('{pc: pc, word: w});
    endfunction

    // ---- monitors: compare every accepted word ----
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("tx16_unexpected", {60'd0, bus.pc_out}, 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tx16", {20'd0, bus.pc_out, bus.opcode, bus.addA, bus.addB,
                               bus.write_add, bus.iformat, bus.jump, bus.jiz},
                      {20'd0, fields(e.pc, e.word)});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus12.out_valid && bus12.out_ready) begin
            if (exp12_q.size() == 0) begin
                check("tx12_unexpected", {60'd0, bus12.pc_out}, 64'hFFFF);
            end else begin
                exp_t e;
                e = exp12_q.pop_front();
                check("tx12", {20'd0, bus12.pc_out, bus12.opcode, bus12.addA, bus12.addB,
                               bus12.write_add, bus12.iformat, bus12.jump, bus12.jiz},
                      {20'd0, fields(e.pc, e.word)});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---- stimulus ----
    initial begin
        prog = '{16'h2005, 16'h1233, 16'h0005, 16'h2423, 16'h3444, 16'h3555, 16'h3666, 16'h3777,
                 16'h3888, 16'h3999, 16'h3AAA, 16'h3BBB, 16'h3CCC, 16'h3DDD, 16'h3EEE, 16'h3FFF};
        rst_n = 1'b0; en = 1'b0; rv = 1'b0; rpc = '0;
        en2 = 1'b0; rv2 = 1'b0; rpc2 = '0;
        bus.out_ready = 1'b0; bus12.out_ready = 1'b0;
`ifdef IMEM_WRITE_EN
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
`endif
        step();
`ifdef IMEM_WRITE_EN
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = prog[i];
            wr_en2 = (i < 12); wr_addr2 = 4'(i); wr_data2 = 16'(16'h1000 + i);
            step();
        end
        wr_en = 1'b0; wr_en2 = 1'b0;
`else
        for (int i = 0; i < 16; i++) dut.imem[i] = prog[i];
        for (int i = 0; i < 12; i++) dut12.imem[i] = 16'(16'h1000 + i);
`endif
        step(); step();

        check("rst_valid",  {63'd0, bus.out_valid}, 64'd0);
        check("rst_pc_out", {60'd0, bus.pc_out}, 64'd0);
        check("rst_fields", {52'd0, bus.jump}, 64'd0);
        check("rst_opcode", {60'd0, bus.opcode}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);

        rst_n = 1'b1;
        step(); step();
        check("idle_no_valid", {63'd0, bus.out_valid}, 64'd0);

        // Sequential fetch from 0, accepted at full rate.
        en = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(4'(i), prog[i]);
        step();
        check("lat_cycle1_valid", {63'd0, bus.out_valid}, 64'd0);
        step();
        check("lat_cycle2_valid", {63'd0, bus.out_valid}, 64'd1);
        check("a0_pc_out", {60'd0, bus.pc_out}, 64'd0);
        check("a0_opcode", {60'd0, bus.opcode}, 64'd2);
        check("a0_addA",   {60'd0, bus.addA}, 64'd0);
        check("a0_addB",   {60'd0, bus.addB}, 64'd0);
        check("a0_write_add", {60'd0, bus.write_add}, 64'd5);
        step();
        check("a1_pc_out", {60'd0, bus.pc_out}, 64'd1);
        step();
        check("a2_pc_out", {60'd0, bus.pc_out}, 64'd2);
        step();
        check("a3_pc_out", {60'd0, bus.pc_out}, 64'd3);
        check("a3_fields", {48'd0, bus.opcode, bus.addA, bus.addB, bus.write_add}, 64'h2423);
        check("a3_jiz",    {56'd0, bus.jiz}, 64'h23);
        step();
        check("a4_pc_out", {60'd0, bus.pc_out}, 64'd4);

        // Backpressure: word 4 must stay frozen.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc_out", {60'd0, bus.pc_out}, 64'd4);
            check("stall_valid",  {63'd0, bus.out_valid}, 64'd1);
            check("stall_opcode", {60'd0, bus.opcode}, 64'd3);
        end
        bus.out_ready = 1'b1;
        step();
        check("after_stall_pc_out", {60'd0, bus.pc_out}, 64'd5);

        // Redirect to 13 while word 5 is unaccepted; plant HALT at addr 3.
        rv = 1'b1; rpc = 4'd13; bus.out_ready = 1'b0;
`ifdef IMEM_WRITE_EN
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hF000;
`else
        dut.imem[3] = 16'hF000;
`endif
        step();
        rv = 1'b0; bus.out_ready = 1'b1;
`ifdef IMEM_WRITE_EN
        wr_en = 1'b0;
`endif
        check("redirect_flush", {63'd0, bus.out_valid}, 64'd0);
        push(4'd13, 16'h3DDD); push(4'd14, 16'h3EEE); push(4'd15, 16'h3FFF);
        push(4'd0, 16'h2005);  push(4'd1, 16'h1233);  push(4'd2, 16'h0005);
        push(4'd3, 16'hF000);
        step();
        check("redirect_target_valid", {63'd0, bus.out_valid}, 64'd1);
        check("redirect_target_pc",    {60'd0, bus.pc_out}, 64'd13);
        step(); step(); step();
        check("wrap16_pc_out", {60'd0, bus.pc_out}, 64'd0);
        step(); step(); step();
        check("halt_word_pc",     {60'd0, bus.pc_out}, 64'd3);
        check("halt_word_opcode", {60'd0, bus.opcode}, 64'hF);
        check("halt_word_valid",  {63'd0, bus.out_valid}, 64'd1);
        step();
        check("halted_no_valid", {63'd0, bus.out_valid}, 64'd0);
        check("halted_flag",     {63'd0, halted}, 64'd1);
        step(); step();
        check("halted_hold_valid", {63'd0, bus.out_valid}, 64'd0);
        check("halted_hold_flag",  {63'd0, halted}, 64'd1);

        // Leave HALTED by redirecting to 0.
        rv = 1'b1; rpc = 4'd0;
        push(4'd0, 16'h2005);
        step();
        rv = 1'b0;
        check("unhalt_flag",  {63'd0, halted}, 64'd0);
        check("unhalt_valid", {63'd0, bus.out_valid}, 64'd0);
        step();
        check("unhalt_pc_out", {60'd0, bus.pc_out}, 64'd0);
        check("unhalt_valid2", {63'd0, bus.out_valid}, 64'd1);

        // en=0 in RUN: pending word drains, no new fetch.
        en = 1'b0;
        step();
        check("en0_drain", {63'd0, bus.out_valid}, 64'd0);
        step();
        check("en0_nofetch", {63'd0, bus.out_valid}, 64'd0);
        en = 1'b1;
        push(4'd1, 16'h1233);
        step();
        check("en1_resume_pc", {60'd0, bus.pc_out}, 64'd1);
        step();
        check("pre_reset_pc", {60'd0, bus.pc_out}, 64'd2);

        // Reset mid-stream with word 2 outstanding.
        rst_n = 1'b0; bus.out_ready = 1'b0;
        step();
        rst_n = 1'b1; en = 1'b0; bus.out_ready = 1'b1;
        check("midrst_valid",  {63'd0, bus.out_valid}, 64'd0);
        check("midrst_pc_out", {60'd0, bus.pc_out}, 64'd0);
        check("midrst_opcode", {60'd0, bus.opcode}, 64'd0);
        check("midrst_halted", {63'd0, halted}, 64'd0);
        step();
        check("midrst_idle", {63'd0, bus.out_valid}, 64'd0);
        en = 1'b1;
        push(4'd0, 16'h2005);
        step();
        check("midrst_lat1", {63'd0, bus.out_valid}, 64'd0);
        step();
        check("midrst_lat2_valid", {63'd0, bus.out_valid}, 64'd1);
        check("midrst_lat2_pc",    {60'd0, bus.pc_out}, 64'd0);
        en = 1'b0;
        step();

        // DEPTH=12 instance: wrap after 11 and redirect_pc modulo DEPTH.
        en2 = 1'b1; bus12.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) push12(4'(i), 16'(16'h1000 + i));
        push12(4'd0, 16'h1000);
        step(); step();
        check("d12_first_pc", {60'd0, bus12.pc_out}, 64'd0);
        repeat (13) step();
        check("d12_wrap_pc",    {60'd0, bus12.pc_out}, 64'd1);
        check("d12_wrap_valid", {63'd0, bus12.out_valid}, 64'd1);
        rv2 = 1'b1; rpc2 = 4'd14; bus12.out_ready = 1'b0;
        step();
        rv2 = 1'b0; bus12.out_ready = 1'b1;
        check("d12_flush", {63'd0, bus12.out_valid}, 64'd0);
        push12(4'd2, 16'h1002);
        step();
        check("d12_mod_valid", {63'd0, bus12.out_valid}, 64'd1);
        check("d12_mod_pc",    {60'd0, bus12.pc_out}, 64'd2);
        en2 = 1'b0;
        step();
        check("d12_drain", {63'd0, bus12.out_valid}, 64'd0);
        step();

        check("queue16_drained", 64'(exp_q.size()), 64'd0);
        check("queue12_drained", 64'(exp12_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
